// File: rtl/ex_mem_stage_buf_if.sv
// EX->MEM stage boundary bundle: EX-side request handshake plus the MEM-side
// decoded memory request. The stage buffer attaches to the slave modport.
interface ex_mem_stage_buf_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PAYLOAD_W = 128
);
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  // EX side
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_addr;
  logic [XLEN-1:0]      in_wdata;
  logic [1:0]           in_size;
  logic [PAYLOAD_W-1:0] in_payload;

  // MEM side
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_addr;
  logic [XLEN-1:0]      out_orig_addr;
  logic [OFF_W-1:0]     out_offset;
  logic [BE_W-1:0]      out_be;
  logic [XLEN-1:0]      out_wdata;
  logic                 out_misaligned;
  logic [PAYLOAD_W-1:0] out_payload;

  modport master (
    output in_valid, in_addr, in_wdata, in_size, in_payload, out_ready,
    input  in_ready, out_valid, out_addr, out_orig_addr, out_offset, out_be,
           out_wdata, out_misaligned, out_payload
  );

  modport slave (
    input  in_valid, in_addr, in_wdata, in_size, in_payload, out_ready,
    output in_ready, out_valid, out_addr, out_orig_addr, out_offset, out_be,
           out_wdata, out_misaligned, out_payload
  );
endinterface

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline register with a 2-entry skid buffer. Memory-side fields
// (aligned address, byte enables, lane-shifted store data) are decoded on enqueue.
module ex_mem_stage_buf #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PAYLOAD_W = 128
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  ex_mem_stage_buf_if.slave bus
);
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  typedef struct packed {
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      orig_addr;
    logic [OFF_W-1:0]     offset;
    logic [BE_W-1:0]      be;
    logic [XLEN-1:0]      wdata;
    logic                 misaligned;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t entry;

  logic             in_ready;
  logic             main_valid;
  logic             accept;
  logic             pop;
  logic [OFF_W-1:0] off;
  logic [BE_W-1:0]  base_mask;
  logic             misaligned;

  // Decode of the incoming request into its memory-side form.
  always_comb begin
    off        = bus.in_addr[OFF_W-1:0];
    base_mask  = '0;
    misaligned = 1'b0;
    unique case (bus.in_size)
      2'd0: begin
        base_mask  = BE_W'(1'b1);
        misaligned = 1'b0;
      end
      2'd1: begin
        base_mask  = BE_W'(2'b11);
        misaligned = off[0];
      end
      2'd2: begin
        base_mask  = BE_W'(4'hF);
        misaligned = |off[1:0];
      end
      default: begin
        base_mask  = '1;
        misaligned = (XLEN == 32) || (|off);
      end
    endcase

    entry.addr       = {bus.in_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    entry.orig_addr  = bus.in_addr;
    entry.offset     = off;
    entry.be         = misaligned ? '0 : (base_mask << off);
    entry.wdata      = bus.in_wdata << {off, 3'b000};
    entry.misaligned = misaligned;
    entry.payload    = bus.in_payload;
  end

  // in_ready depends only on registered state, so MEM stalls never reach EX combinationally.
  assign in_ready   = (state_q != StFull);
  assign main_valid = (state_q != StEmpty);
  assign accept     = bus.in_valid && in_ready;
  assign pop        = main_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StBusy;
          main_d  = entry;
        end
      end
      StBusy: begin
        if (accept && pop) begin
          main_d = entry;
        end else if (accept) begin
          state_d = StFull;
          skid_d  = entry;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          state_d = StBusy;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush drops any same-cycle accept; a same-cycle pop is simply consumed.
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = main_valid;
  assign bus.out_addr       = main_q.addr;
  assign bus.out_orig_addr  = main_q.orig_addr;
  assign bus.out_offset     = main_q.offset;
  // Stale data may remain in main after a flush or drain; enables must not.
  assign bus.out_be         = main_valid ? main_q.be : '0;
  assign bus.out_wdata      = main_q.wdata;
  assign bus.out_misaligned = main_q.misaligned;
  assign bus.out_payload    = main_q.payload;

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Bench for ex_mem_stage_buf: XLEN=32 and XLEN=64 instances share one stimulus
// stream; a byte-lane reference model feeds a scoreboard checked at every pop.
module tb_ex_mem_stage_buf;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, in_valid, out_ready;
  logic [63:0]  in_addr, in_wdata;
  logic [1:0]   in_size;
  logic [127:0] in_payload;

  ex_mem_stage_buf_if #(.XLEN(32), .PAYLOAD_W(128)) b32 ();
  ex_mem_stage_buf_if #(.XLEN(64), .PAYLOAD_W(128)) b64 ();

  assign b32.in_valid   = in_valid;
  assign b32.in_addr    = in_addr[31:0];
  assign b32.in_wdata   = in_wdata[31:0];
  assign b32.in_size    = in_size;
  assign b32.in_payload = in_payload;
  assign b32.out_ready  = out_ready;
  assign b64.in_valid   = in_valid;
  assign b64.in_addr    = in_addr;
  assign b64.in_wdata   = in_wdata;
  assign b64.in_size    = in_size;
  assign b64.in_payload = in_payload;
  assign b64.out_ready  = out_ready;

  ex_mem_stage_buf #(.XLEN(32), .PAYLOAD_W(128)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b32.slave)
  );
  ex_mem_stage_buf #(.XLEN(64), .PAYLOAD_W(128)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b64.slave)
  );

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  off;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        mis;
  } lane_t;

  typedef struct {
    lane_t        l32;
    lane_t        l64;
    logic [63:0]  orig;
    logic [127:0] payload;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic [31:0] a32;
    logic [1:0]  off32;
    logic [3:0]  be32;
    logic [31:0] w32;
    logic        m32;
    logic [63:0] a64;
    logic [2:0]  off64;
    logic [7:0]  be64;
    logic [63:0] w64;
    logic        m64;
  } vec_t;

  exp_t sb[$];
  vec_t vt[6];
  int   n_tests, n_fail, n_pop, pop_base;

  // Byte-lane reference: lane i enabled if it falls inside [off, off+nbytes).
  function automatic lane_t ref_lane(input int bw, input logic [63:0] a, input logic [63:0] w,
                                     input logic [1:0] sz);
    lane_t r;
    int    nb, off;
    nb    = 1 << sz;
    off   = int'(a[2:0]) % bw;
    r.off = 3'(off);
    r.mis = (nb > bw) || ((off % nb) != 0);
    r.be  = '0;
    for (int i = 0; i < bw; i++) begin
      if (!r.mis && i >= off && i < off + nb) r.be[i] = 1'b1;
    end
    r.wdata = w << (8 * off);
    r.addr  = a - 64'(off);
    if (bw == 4) begin
      r.wdata = {32'b0, r.wdata[31:0]};
      r.addr  = {32'b0, r.addr[31:0]};
    end
    return r;
  endfunction

  function automatic exp_t mk_exp();
    exp_t e;
    e.l32     = ref_lane(4, in_addr, in_wdata, in_size);
    e.l64     = ref_lane(8, in_addr, in_wdata, in_size);
    e.orig    = in_addr;
    e.payload = in_payload;
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_cycle();
    logic ready_m, valid_m;
    exp_t e;
    ready_m = (sb.size() < 2);
    valid_m = (sb.size() > 0);
    chk("in_ready32", b32.in_ready, ready_m);
    chk("in_ready64", b64.in_ready, ready_m);
    chk("out_valid32", b32.out_valid, valid_m);
    chk("out_valid64", b64.out_valid, valid_m);
    if (!valid_m) begin
      chk("idle_be32", b32.out_be, 0);
      chk("idle_be64", b64.out_be, 0);
    end else if (out_ready) begin
      e = sb[0];
      chk("addr32", b32.out_addr, e.l32.addr);
      chk("orig32", b32.out_orig_addr, e.orig[31:0]);
      chk("off32", b32.out_offset, e.l32.off);
      chk("be32", b32.out_be, e.l32.be);
      chk("wdata32", b32.out_wdata, e.l32.wdata);
      chk("mis32", b32.out_misaligned, e.l32.mis);
      chk("payload32", b32.out_payload, e.payload);
      chk("addr64", b64.out_addr, e.l64.addr);
      chk("orig64", b64.out_orig_addr, e.orig);
      chk("off64", b64.out_offset, e.l64.off);
      chk("be64", b64.out_be, e.l64.be);
      chk("wdata64", b64.out_wdata, e.l64.wdata);
      chk("mis64", b64.out_misaligned, e.l64.mis);
      chk("payload64", b64.out_payload, e.payload);
    end
  endtask

  // One clock: check at the falling edge, then advance the model with the edge.
  task automatic cycle();
    logic acc, pop;
    exp_t e;
    check_cycle();
    acc = in_valid && (sb.size() < 2);
    pop = (sb.size() > 0) && out_ready;
    e   = mk_exp();
    @(posedge clk);
    if (rst) begin
      sb.delete();
    end else if (flush) begin
      if (pop) n_pop++;
      sb.delete();
    end else begin
      if (pop) begin
        sb.delete(0);
        n_pop++;
      end
      if (acc) sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready32"}, b32.in_ready, 1);
    chk({tag, "_valid32"}, b32.out_valid, 0);
    chk({tag, "_addr32"}, b32.out_addr, 0);
    chk({tag, "_orig32"}, b32.out_orig_addr, 0);
    chk({tag, "_be32"}, b32.out_be, 0);
    chk({tag, "_wdata32"}, b32.out_wdata, 0);
    chk({tag, "_mis32"}, b32.out_misaligned, 0);
    chk({tag, "_pay32"}, b32.out_payload, 0);
    chk({tag, "_ready64"}, b64.in_ready, 1);
    chk({tag, "_valid64"}, b64.out_valid, 0);
    chk({tag, "_addr64"}, b64.out_addr, 0);
    chk({tag, "_be64"}, b64.out_be, 0);
    chk({tag, "_wdata64"}, b64.out_wdata, 0);
    chk({tag, "_pay64"}, b64.out_payload, 0);
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] w, input logic [1:0] sz,
                       input logic [127:0] p);
    in_valid   = 1'b1;
    in_addr    = a;
    in_wdata   = w;
    in_size    = sz;
    in_payload = p;
  endtask

  initial begin
    vt[0] = '{64'h1000_0006, 64'hBEEF, 2'd1, 32'h1000_0004, 2'd2, 4'hC, 32'hBEEF_0000, 1'b0,
              64'h1000_0000, 3'd6, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b0};
    vt[1] = '{64'h23, 64'hAA, 2'd0, 32'h20, 2'd3, 4'h8, 32'hAA00_0000, 1'b0,
              64'h20, 3'd3, 8'h08, 64'hAA00_0000, 1'b0};
    vt[2] = '{64'h22, 64'h1122_3344, 2'd2, 32'h20, 2'd2, 4'h0, 32'h3344_0000, 1'b1,
              64'h20, 3'd2, 8'h00, 64'h1122_3344_0000, 1'b1};
    vt[3] = '{64'h8, 64'h0123_4567_89AB_CDEF, 2'd3, 32'h8, 2'd0, 4'h0, 32'h89AB_CDEF, 1'b1,
              64'h8, 3'd0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vt[4] = '{64'hC, 64'hDEAD_BEEF, 2'd2, 32'hC, 2'd0, 4'hF, 32'hDEAD_BEEF, 1'b0,
              64'h8, 3'd4, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1'b0};
    vt[5] = '{64'h5, 64'h1234, 2'd1, 32'h4, 2'd1, 4'h0, 32'h0012_3400, 1'b1,
              64'h0, 3'd5, 8'h00, 64'h0012_3400_0000_0000, 1'b1};

    n_tests = 0;
    n_fail  = 0;
    n_pop   = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_addr = '0; in_wdata = '0; in_size = '0; in_payload = '0;
    @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    check_zero("reset");
    cycle();

    // Directed decode vectors, one entry at a time.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].addr, vt[i].wdata, vt[i].size, {64'hC0DE, 64'(i)});
      cycle();
      in_valid = 1'b0;
      chk("v_addr32", b32.out_addr, vt[i].a32);
      chk("v_off32", b32.out_offset, vt[i].off32);
      chk("v_be32", b32.out_be, vt[i].be32);
      chk("v_wdata32", b32.out_wdata, vt[i].w32);
      chk("v_mis32", b32.out_misaligned, vt[i].m32);
      chk("v_addr64", b64.out_addr, vt[i].a64);
      chk("v_off64", b64.out_offset, vt[i].off64);
      chk("v_be64", b64.out_be, vt[i].be64);
      chk("v_wdata64", b64.out_wdata, vt[i].w64);
      chk("v_mis64", b64.out_misaligned, vt[i].m64);
      cycle();
    end

    // Backpressure: A and B fill the buffer, C stalls, then all drain in order.
    out_ready = 1'b0;
    pop_base  = n_pop;
    drive(64'h100, 64'h11, 2'd2, 128'hA);
    cycle();
    drive(64'h104, 64'h22, 2'd2, 128'hB);
    cycle();
    drive(64'h108, 64'h33, 2'd2, 128'hC);
    cycle();
    chk("full_ready", b32.in_ready, 0);
    chk("hold_pay", b32.out_payload, 128'hA);
    cycle();
    chk("hold_pay2", b64.out_payload, 128'hA);
    chk("hold_addr", b64.out_addr, 64'h100);
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("drain_cnt", n_pop - pop_base, 3);

    // Flush in FULL with a same-cycle offer.
    out_ready = 1'b0;
    drive(64'h200, 64'h44, 2'd0, 128'hD1);
    cycle();
    drive(64'h201, 64'h55, 2'd0, 128'hD2);
    cycle();
    drive(64'h202, 64'h66, 2'd0, 128'hD3);
    flush = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", b32.out_valid, 0);
    chk("flush_ready", b64.in_ready, 1);
    chk("flush_be32", b32.out_be, 0);
    chk("flush_be64", b64.out_be, 0);
    out_ready = 1'b1;
    cycle();
    cycle();

    // Reset in FULL together with flush and an offer.
    out_ready = 1'b0;
    drive(64'h300, 64'h77, 2'd1, 128'hE1);
    cycle();
    drive(64'h302, 64'h88, 2'd1, 128'hE2);
    cycle();
    drive(64'h304, 64'h99, 2'd1, 128'hE3);
    rst   = 1'b1;
    flush = 1'b1;
    cycle();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_zero("rst_mid");
    out_ready = 1'b1;
    cycle();
    cycle();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 24) == 0);
      in_size    = 2'($urandom_range(0, 3));
      in_addr    = {$urandom, $urandom};
      in_wdata   = {$urandom, $urandom};
      in_payload = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
